pid_pwm_drv: RTL and testbench



---
 rtl/pid_pwm_drv.sv | 154 +++++++++++++++
 tb/tb_pid_pwm_drv.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pid_pwm_drv.sv
`default_nettype none
// ============================================================================
// Module      : pid_pwm_drv
// Description : Signed PID command to glitch-free fwd/rev PWM driver with
//               minimum-duty offset, saturation and reversal dead time.
// Revision    : 1.0 - initial release
// ============================================================================
module pid_pwm_drv #(
    parameter logic [10:0] MIN_DUTY = 11'h0A0,
    parameter int          DEAD_CYC = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        cntrl_vld,
    input  logic [11:0] PID_cntrl,
    output logic        PWM_fwd,
    output logic        PWM_rev,
    output logic        prd_strt,
    output logic        sat,
    output logic        busy_dead
);

    localparam logic [1:0]  c_OFF       = 2'd0;
    localparam logic [1:0]  c_RUN       = 2'd1;
    localparam logic [1:0]  c_DEAD      = 2'd2;
    localparam logic [10:0] c_CNT_MAX   = 11'h7FF;
    localparam logic [7:0]  c_DEAD_LAST = 8'(DEAD_CYC - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [10:0] r_cnt;
    logic [7:0]  r_dead_cnt;
    logic [11:0] r_shadow;
    logic [10:0] r_duty;
    logic        r_dir;
    logic        r_sat;
    logic [10:0] r_pend_duty;
    logic        r_pend_dir;
    logic        r_pend_sat;

    logic [11:0] w_src;
    logic [12:0] w_ext;
    logic [12:0] w_mag;
    logic [12:0] w_sum;
    logic        w_zero;
    logic        w_clip;
    logic [10:0] w_ld_duty;
    logic        w_ld_dir;
    logic        w_ld_sat;
    logic        w_ld_rev;
    logic        w_load;
    logic        w_dead_exit;
    logic        w_run_stay;

    // A strobe coincident with a load point bypasses the shadow register.
    assign w_src     = cntrl_vld ? PID_cntrl : r_shadow;
    assign w_ext     = {w_src[11], w_src};
    assign w_mag     = w_src[11] ? (13'd0 - w_ext) : w_ext;
    assign w_sum     = w_mag + {2'b00, MIN_DUTY};
    assign w_zero    = (w_src == 12'd0);
    assign w_clip    = (w_sum > 13'd2047);
    assign w_ld_duty = w_zero ? 11'd0 : (w_clip ? c_CNT_MAX : w_sum[10:0]);
    assign w_ld_sat  = !w_zero && w_clip;
    assign w_ld_dir  = w_zero ? r_dir : w_src[11];
    assign w_ld_rev  = (w_ld_duty != 11'd0) && (w_ld_dir != r_dir);

    assign w_load      = en && ((r_state == c_OFF) ||
                                ((r_state == c_RUN) && (r_cnt == c_CNT_MAX)));
    assign w_dead_exit = en && (r_state == c_DEAD) && (r_dead_cnt == c_DEAD_LAST);
    assign w_run_stay  = (r_state == c_RUN) && (w_state_nxt == c_RUN);
    assign sat         = r_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        prd_strt    = 1'b0;
        busy_dead   = 1'b0;
        case (r_state)
            c_OFF: begin
                if (en) begin
                    w_state_nxt = w_ld_rev ? c_DEAD : c_RUN;
                end
            end
            c_RUN: begin
                prd_strt = (r_cnt == 11'd0);
                if (!en) begin
                    w_state_nxt = c_OFF;
                end else if ((r_cnt == c_CNT_MAX) && w_ld_rev) begin
                    w_state_nxt = c_DEAD;
                end
            end
            c_DEAD: begin
                busy_dead = 1'b1;
                if (!en) begin
                    w_state_nxt = c_OFF;
                end else if (r_dead_cnt == c_DEAD_LAST) begin
                    w_state_nxt = c_RUN;
                end
            end
            default: w_state_nxt = c_OFF;
        endcase
    end

    // A reversal is held in the pending set until dead time completes, so an
    // enable drop mid-dead-time cannot let the new direction skip the gap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= 11'd0;
            r_dead_cnt  <= 8'd0;
            r_shadow    <= 12'd0;
            r_duty      <= 11'd0;
            r_dir       <= 1'b0;
            r_sat       <= 1'b0;
            r_pend_duty <= 11'd0;
            r_pend_dir  <= 1'b0;
            r_pend_sat  <= 1'b0;
            PWM_fwd     <= 1'b0;
            PWM_rev     <= 1'b0;
        end else begin
            if (cntrl_vld) begin
                r_shadow <= PID_cntrl;
            end
            r_cnt      <= w_run_stay ? (r_cnt + 11'd1) : 11'd0;
            r_dead_cnt <= (r_state == c_DEAD) ? (r_dead_cnt + 8'd1) : 8'd0;
            if (w_load) begin
                if (w_ld_rev) begin
                    r_pend_duty <= w_ld_duty;
                    r_pend_dir  <= w_ld_dir;
                    r_pend_sat  <= w_ld_sat;
                end else begin
                    r_duty <= w_ld_duty;
                    r_dir  <= w_ld_dir;
                    r_sat  <= w_ld_sat;
                end
            end else if (w_dead_exit) begin
                r_duty <= r_pend_duty;
                r_dir  <= r_pend_dir;
                r_sat  <= r_pend_sat;
            end
            PWM_fwd <= w_run_stay && !r_dir && (r_cnt < r_duty);
            PWM_rev <= w_run_stay &&  r_dir && (r_cnt < r_duty);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pid_pwm_drv.sv
`default_nettype none
// ============================================================================
// Module      : tb_pid_pwm_drv
// Description : Directed self-checking bench for pid_pwm_drv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pid_pwm_drv;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        cntrl_vld;
    logic [11:0] PID_cntrl;
    logic        PWM_fwd;
    logic        PWM_rev;
    logic        prd_strt;
    logic        sat;
    logic        busy_dead;

    int   n_total = 0;
    int   n_bad   = 0;
    logic both_seen = 1'b0;

    pid_pwm_drv dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .cntrl_vld (cntrl_vld),
        .PID_cntrl (PID_cntrl),
        .PWM_fwd   (PWM_fwd),
        .PWM_rev   (PWM_rev),
        .prd_strt  (prd_strt),
        .sat       (sat),
        .busy_dead (busy_dead)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (PWM_fwd && PWM_rev) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, act, exp);
        end
    endtask

    task automatic wait_prd(input string tag);
        int k = 0;
        @(negedge clk);
        while (!prd_strt && k < 5000) begin
            @(negedge clk);
            k++;
        end
        check(tag, {31'd0, prd_strt}, 32'd1);
    endtask

    // Observes one full period starting at the prd_strt sample, optionally
    // strobing up to two commands at given cycle offsets (cnt values).
    task automatic meas(input string tag, input int s1, input logic [11:0] v1,
                        input int s2, input logic [11:0] v2,
                        input int e_fwd, input int e_rev, input int e_sat);
        int   nf = 0;
        int   nr = 0;
        int   np = 0;
        logic s  = 1'b0;
        check({tag, "_start"}, {31'd0, prd_strt}, 32'd1);
        for (int i = 0; i < 2048; i++) begin
            if (PWM_fwd)  nf++;
            if (PWM_rev)  nr++;
            if (prd_strt) np++;
            if (i == 1)   s = sat;
            if (i == s1) begin
                cntrl_vld = 1'b1;
                PID_cntrl = v1;
            end else if (i == s2) begin
                cntrl_vld = 1'b1;
                PID_cntrl = v2;
            end else begin
                cntrl_vld = 1'b0;
            end
            @(negedge clk);
        end
        cntrl_vld = 1'b0;
        check({tag, "_fwd"}, nf, e_fwd);
        check({tag, "_rev"}, nr, e_rev);
        check({tag, "_sat"}, {31'd0, s}, e_sat);
        check({tag, "_prd"}, np, 32'd1);
    endtask

    task automatic dead_meas(input string tag);
        int   n  = 0;
        logic hi = 1'b0;
        while (busy_dead && n < 300) begin
            if (PWM_fwd || PWM_rev) hi = 1'b1;
            n++;
            @(negedge clk);
        end
        check({tag, "_len"}, n, 32'd32);
        check({tag, "_low"}, {31'd0, hi}, 32'd0);
        check({tag, "_prd"}, {31'd0, prd_strt}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        cntrl_vld = 1'b0;
        PID_cntrl = 12'h000;
        repeat (3) @(negedge clk);
        check("rst_fwd",  {31'd0, PWM_fwd},   32'd0);
        check("rst_rev",  {31'd0, PWM_rev},   32'd0);
        check("rst_prd",  {31'd0, prd_strt},  32'd0);
        check("rst_sat",  {31'd0, sat},       32'd0);
        check("rst_dead", {31'd0, busy_dead}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        cntrl_vld = 1'b1;
        PID_cntrl = 12'h100;
        @(negedge clk);
        cntrl_vld = 1'b0;
        check("off_prd", {31'd0, prd_strt}, 32'd0);
        en = 1'b1;
        wait_prd("first_prd");

        // 0x100 -> 416; two strobes in one period, last one wins (0x020 -> 192)
        meas("fwd416",  100, 12'h010, 200, 12'h020, 416, 0, 0);
        // strobe at cnt==2047 takes effect at the very next period
        meas("fwd192", 2047, 12'h100,  -1, 12'h000, 192, 0, 0);
        // reversal mid-period: current period unchanged, then dead time
        meas("pre_rev", 500, 12'hF00,  -1, 12'h000, 416, 0, 0);
        dead_meas("dead1");
        meas("rev416",  300, 12'h800,  -1, 12'h000, 0, 416, 0);
        meas("rev_sat", 300, 12'h7FF,  -1, 12'h000, 0, 2047, 1);
        dead_meas("dead2");
        meas("fwd_sat", 300, 12'h000,  -1, 12'h000, 2047, 0, 1);
        meas("zero",     10, 12'h100,  -1, 12'h000, 0, 0, 0);

        // enable drop at cnt==100 while forward is high
        repeat (100) @(negedge clk);
        check("en_hi", {31'd0, PWM_fwd}, 32'd1);
        en = 1'b0;
        @(negedge clk);
        check("en_off_fwd", {31'd0, PWM_fwd},  32'd0);
        check("en_off_prd", {31'd0, prd_strt}, 32'd0);
        en = 1'b1;
        @(negedge clk);
        check("en_restart", {31'd0, prd_strt}, 32'd1);
        meas("en_run",   -1, 12'h000,  -1, 12'h000, 416, 0, 0);

        // reset pulsed during dead time
        meas("pre_rst",   5, 12'hF00,  -1, 12'h000, 416, 0, 0);
        check("rst_in_dead", {31'd0, busy_dead}, 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_dead", {31'd0, busy_dead}, 32'd0);
        check("arst_fwd",  {31'd0, PWM_fwd},   32'd0);
        check("arst_rev",  {31'd0, PWM_rev},   32'd0);
        check("arst_prd",  {31'd0, prd_strt},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_prd("post_rst_prd");
        meas("post_rst", -1, 12'h000,  -1, 12'h000, 0, 0, 0);

        check("excl", {31'd0, both_seen}, 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
